sync_rr_arbiter: RTL and testbench

- Shares one downstream resource among N requesters whose request lines are asynchronous to clk.
- Each request passes through its own two-flop synchronizer. A round-robin arbiter then issues one-hot grants using a four-phase req/grant handshake.
- Sits between asynchronous peripherals or external agents and a single shared datapath or bus port.

---
 rtl/sync_rr_arbiter_if.sv | 26 ++
 rtl/sync_rr_arbiter.sv | 159 +++++++++++++++
 tb/tb_sync_rr_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_rr_arbiter_if.sv
// Request/grant bundle for sync_rr_arbiter.
// master = requester side, slave = arbiter side.
interface sync_rr_arbiter_if #(
   parameter int N = 4
);
   localparam int OW = $clog2(N);

   logic [N-1:0]  req;
   logic [N-1:0]  grant;
   logic          busy;
   logic [OW-1:0] owner;

   modport master (
      output req,
      input  grant,
      input  busy,
      input  owner
   );

   modport slave (
      input  req,
      output grant,
      output busy,
      output owner
   );
endinterface

// File: rtl/sync_rr_arbiter.sv
// Round-robin arbiter for N asynchronous four-phase requesters, each request
// synchronized first. Define SYNC_ARB_SYNC3_EN for a three-flop synchronizer.
module sync_rr_arbiter #(
   parameter int N = 4
) (
   input  logic             clk,
   input  logic             reset,
   sync_rr_arbiter_if.slave arb
);
   localparam int OW = $clog2(N);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   logic [N-1:0]  s1_r;
`ifdef SYNC_ARB_SYNC3_EN
   logic [N-1:0]  s2_r;
`endif
   logic [N-1:0]  s_req_r;

   state_t        state_r;
   state_t        state_s;
   logic [N-1:0]  grant_r;
   logic [N-1:0]  grant_s;
   logic          busy_r;
   logic          busy_s;
   logic [OW-1:0] owner_r;
   logic [OW-1:0] owner_s;
   logic [OW-1:0] ptr_r;
   logic [OW-1:0] ptr_s;
   logic [OW:0]   pick_s;

   function automatic logic [N-1:0] onehot(input logic [OW-1:0] idx);
      logic [N-1:0] v;
      v = {N{1'b0}};
      for (int i = 0; i < N; i++) begin
         if (OW'(i) == idx) begin
            v[i] = 1'b1;
         end
      end
      return v;
   endfunction

   function automatic logic [OW-1:0] next_idx(input logic [OW-1:0] idx);
      logic [OW-1:0] r;
      if (idx == OW'(N - 1)) begin
         r = {OW{1'b0}};
      end else begin
         r = idx + OW'(1);
      end
      return r;
   endfunction

   // Returns {found, index}: first set bit searching upward from ptr with wrap.
   // Rotating a doubled copy puts requester (ptr+k) mod N at bit k.
   function automatic logic [OW:0] pick_winner(input logic [N-1:0]  reqv,
                                                input logic [OW-1:0] ptr);
      logic [2*N-1:0] dbl;
      logic [N-1:0]   rot;
      logic           found;
      logic [OW:0]    sum;
      dbl   = {reqv, reqv} >> ptr;
      rot   = dbl[N-1:0];
      found = 1'b0;
      sum   = {(OW+1){1'b0}};
      for (int i = 0; i < N; i++) begin
         if (!found && rot[i]) begin
            found = 1'b1;
            sum   = {1'b0, ptr} + (OW+1)'(i);
         end
      end
      if (sum >= (OW+1)'(N)) begin
         sum = sum - (OW+1)'(N);
      end
      return {found, sum[OW-1:0]};
   endfunction

   // Synchronizer chain; raw req only ever reaches s1_r.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_r    <= {N{1'b0}};
`ifdef SYNC_ARB_SYNC3_EN
         s2_r    <= {N{1'b0}};
`endif
         s_req_r <= {N{1'b0}};
      end else begin
         s1_r    <= arb.req;
`ifdef SYNC_ARB_SYNC3_EN
         s2_r    <= s1_r;
         s_req_r <= s2_r;
`else
         s_req_r <= s1_r;
`endif
      end
   end

   // Next-state and next-output logic; outputs are registered below.
   always_comb begin
      state_s = state_r;
      grant_s = grant_r;
      busy_s  = busy_r;
      owner_s = owner_r;
      ptr_s   = ptr_r;
      pick_s  = pick_winner(s_req_r, ptr_r);
      case (state_r)
         ST_IDLE: begin
            if (pick_s[OW]) begin
               state_s = ST_BUSY;
               grant_s = onehot(pick_s[OW-1:0]);
               busy_s  = 1'b1;
               owner_s = pick_s[OW-1:0];
            end else begin
               grant_s = {N{1'b0}};
               busy_s  = 1'b0;
            end
         end
         ST_BUSY: begin
            // No preemption: only the owner's own release ends the grant.
            if (s_req_r[owner_r]) begin
               grant_s = onehot(owner_r);
               busy_s  = 1'b1;
            end else begin
               state_s = ST_IDLE;
               grant_s = {N{1'b0}};
               busy_s  = 1'b0;
               ptr_s   = next_idx(owner_r);
            end
         end
         default: begin
            state_s = ST_IDLE;
            grant_s = {N{1'b0}};
            busy_s  = 1'b0;
         end
      endcase
   end

   // Arbiter state, pointer and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
         grant_r <= {N{1'b0}};
         busy_r  <= 1'b0;
         owner_r <= {OW{1'b0}};
         ptr_r   <= {OW{1'b0}};
      end else begin
         state_r <= state_s;
         grant_r <= grant_s;
         busy_r  <= busy_s;
         owner_r <= owner_s;
         ptr_r   <= ptr_s;
      end
   end

   assign arb.grant = grant_r;
   assign arb.busy  = busy_r;
   assign arb.owner = owner_r;
endmodule

// File: tb/tb_sync_rr_arbiter.sv
// Self-checking bench for sync_rr_arbiter: directed scenarios plus random
// request traffic against a delay-line + round-robin reference model.
module tb_sync_rr_arbiter;
   localparam int N  = 4;
   localparam int OW = $clog2(N);
`ifdef SYNC_ARB_SYNC3_EN
   localparam int SYNC = 3;
`else
   localparam int SYNC = 2;
`endif

   logic clk = 1'b0;
   logic reset;

   sync_rr_arbiter_if #(.N(N)) arb_if ();

   sync_rr_arbiter #(.N(N)) dut (
      .clk   (clk),
      .reset (reset),
      .arb   (arb_if.slave)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: request history (index 0 = newest sample) and arbiter view.
   logic [N-1:0]  hist [SYNC];
   int            m_owner;
   int            m_ptr;
   int            m_last;
   logic [N-1:0]  exp_grant;
   logic          exp_busy;
   logic [OW-1:0] exp_owner;

   task automatic tick();
      logic [N-1:0] sreq;
      logic [N-1:0] one;
      int c;
      @(posedge clk);
      #1;
      if (reset) begin
         for (int j = 0; j < SYNC; j++) hist[j] = '0;
         m_owner = -1;
         m_ptr   = 0;
         m_last  = 0;
      end else begin
         sreq = hist[SYNC-1];
         if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
               c = (m_ptr + k) % N;
               if (m_owner < 0 && sreq[c]) begin
                  m_owner = c;
                  m_last  = c;
               end
            end
         end else if (!sreq[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
         end
         for (int j = SYNC - 1; j > 0; j--) hist[j] = hist[j-1];
         hist[0] = arb_if.req;
      end
      one       = 4'b0001;
      exp_grant = (m_owner < 0) ? 4'b0000 : (one << m_owner);
      exp_busy  = (m_owner >= 0);
      exp_owner = OW'(m_last);
   endtask

   task automatic do_reset();
      arb_if.req = 4'b0000;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      arb_if.req = 4'b0000;
      reset = 1'b1;
      tick();
      tick();
      n_checks++;
      if (arb_if.grant !== 4'b0000) $display("FAIL reset_grant: got %b expected 0000", arb_if.grant);
      else n_pass++;
      n_checks++;
      if (arb_if.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", arb_if.busy);
      else n_pass++;
      n_checks++;
      if (arb_if.owner !== 2'd0) $display("FAIL reset_owner: got %0d expected 0", arb_if.owner);
      else n_pass++;
      reset = 1'b0;
   endtask

   task automatic test_single_latency();
      logic [N-1:0] exp;
      do_reset();
      arb_if.req = 4'b0001;
      for (int e = 1; e <= SYNC + 1; e++) begin
         tick();
         exp = (e == SYNC + 1) ? 4'b0001 : 4'b0000;
         n_checks++;
         if (arb_if.grant !== exp) $display("FAIL single_rise edge %0d: grant=%b expected %b", e, arb_if.grant, exp);
         else n_pass++;
      end
      n_checks++;
      if (arb_if.busy !== 1'b1 || arb_if.owner !== 2'd0)
         $display("FAIL single_busy_owner: busy=%b owner=%0d expected 1/0", arb_if.busy, arb_if.owner);
      else n_pass++;
      tick();
      tick();
      arb_if.req = 4'b0000;
      for (int e = 1; e <= SYNC + 1; e++) begin
         tick();
         exp = (e == SYNC + 1) ? 4'b0000 : 4'b0001;
         n_checks++;
         if (arb_if.grant !== exp || arb_if.busy !== (exp != 4'b0000))
            $display("FAIL single_fall edge %0d: grant=%b busy=%b expected %b", e, arb_if.grant, arb_if.busy, exp);
         else n_pass++;
      end
   endtask

   task automatic test_all_requesters();
      logic [N-1:0] seq [5];
      logic [N-1:0] exp_seq [5];
      int           hold [N];
      int           ngr;
      logic [N-1:0] g;
      logic [N-1:0] prev;
      exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      for (int i = 0; i < N; i++) hold[i] = 0;
      for (int k = 0; k < 5; k++) seq[k] = 4'b0000;
      ngr  = 0;
      prev = 4'b0000;
      do_reset();
      arb_if.req = 4'b1111;
      for (int cyc = 0; cyc < 200 && ngr < 5; cyc++) begin
         tick();
         g = arb_if.grant;
         n_checks++;
         if (g !== exp_grant) $display("FAIL all_model cyc %0d: grant=%b expected %b", cyc, g, exp_grant);
         else n_pass++;
         n_checks++;
         if (prev != 4'b0000 && g != 4'b0000 && g != prev)
            $display("FAIL all_gap cyc %0d: grant=%b directly after %b, expected an idle cycle", cyc, g, prev);
         else n_pass++;
         if (g != 4'b0000 && prev == 4'b0000) begin
            seq[ngr] = g;
            ngr++;
         end
         prev = g;
         for (int i = 0; i < N; i++) begin
            if (g[i]) begin
               hold[i]++;
               if (hold[i] == 2) arb_if.req[i] = 1'b0;
            end else if (hold[i] > 0) begin
               arb_if.req[i] = 1'b1;
               hold[i] = 0;
            end
         end
      end
      n_checks++;
      if (ngr !== 5) $display("FAIL all_count: got %0d grants expected 5", ngr);
      else n_pass++;
      for (int k = 0; k < 5; k++) begin
         n_checks++;
         if (seq[k] !== exp_seq[k]) $display("FAIL all_order[%0d]: grant=%b expected %b", k, seq[k], exp_seq[k]);
         else n_pass++;
      end
      arb_if.req = 4'b0000;
   endtask

   task automatic test_no_preempt();
      do_reset();
      arb_if.req = 4'b0010;
      for (int w = 0; w < 10 && arb_if.grant == 4'b0000; w++) tick();
      n_checks++;
      if (arb_if.grant !== 4'b0010 || arb_if.owner !== 2'd1)
         $display("FAIL np_first: grant=%b owner=%0d expected 0010/1", arb_if.grant, arb_if.owner);
      else n_pass++;
      arb_if.req = 4'b1010;
      for (int c = 0; c < 6; c++) begin
         tick();
         n_checks++;
         if (arb_if.grant !== 4'b0010) $display("FAIL np_hold cyc %0d: grant=%b expected 0010", c, arb_if.grant);
         else n_pass++;
      end
      arb_if.req = 4'b1000;
      for (int w = 0; w < 10 && arb_if.grant != 4'b0000; w++) tick();
      n_checks++;
      if (arb_if.grant !== 4'b0000) $display("FAIL np_release: grant=%b expected 0000", arb_if.grant);
      else n_pass++;
      tick();
      n_checks++;
      if (arb_if.grant !== 4'b1000 || arb_if.owner !== 2'd3)
         $display("FAIL np_next: grant=%b owner=%0d expected 1000/3", arb_if.grant, arb_if.owner);
      else n_pass++;
      arb_if.req = 4'b0000;
      for (int w = 0; w < 10 && arb_if.grant != 4'b0000; w++) tick();
      for (int c = 0; c < SYNC + 1; c++) tick();
      arb_if.req = 4'b0011;
      for (int w = 0; w < 10 && arb_if.grant == 4'b0000; w++) tick();
      n_checks++;
      if (arb_if.grant !== 4'b0001 || arb_if.grant !== exp_grant)
         $display("FAIL np_wrap: grant=%b expected 0001 (model %b)", arb_if.grant, exp_grant);
      else n_pass++;
      arb_if.req = 4'b0000;
   endtask

   task automatic test_reset_mid_grant();
      logic [N-1:0] exp;
      do_reset();
      arb_if.req = 4'b0100;
      for (int w = 0; w < 10 && arb_if.grant == 4'b0000; w++) tick();
      tick();
      reset = 1'b1;
      tick();
      n_checks++;
      if (arb_if.grant !== 4'b0000 || arb_if.owner !== 2'd0 || arb_if.busy !== 1'b0)
         $display("FAIL rst_mid: grant=%b owner=%0d busy=%b expected 0000/0/0", arb_if.grant, arb_if.owner, arb_if.busy);
      else n_pass++;
      reset = 1'b0;
      for (int e = 1; e <= SYNC + 1; e++) begin
         tick();
         exp = (e == SYNC + 1) ? 4'b0100 : 4'b0000;
         n_checks++;
         if (arb_if.grant !== exp) $display("FAIL rst_regrant edge %0d: grant=%b expected %b", e, arb_if.grant, exp);
         else n_pass++;
      end
      arb_if.req = 4'b0000;
      for (int w = 0; w < 10 && arb_if.grant != 4'b0000; w++) tick();
   endtask

   task automatic test_pulse();
      int cnt;
      do_reset();
      arb_if.req = 4'b0100;
      tick();
      arb_if.req = 4'b0000;
      cnt = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (arb_if.grant == 4'b0100) cnt++;
         n_checks++;
         if (arb_if.grant !== exp_grant) $display("FAIL pulse_model cyc %0d: grant=%b expected %b", c, arb_if.grant, exp_grant);
         else n_pass++;
      end
      n_checks++;
      if (cnt !== 1) $display("FAIL pulse_len: grant 0100 for %0d cycles expected 1", cnt);
      else n_pass++;
      arb_if.req = 4'b1001;
      for (int w = 0; w < 10 && arb_if.grant == 4'b0000; w++) tick();
      n_checks++;
      if (arb_if.grant !== 4'b1000) $display("FAIL pulse_ptr: grant=%b expected 1000", arb_if.grant);
      else n_pass++;
      arb_if.req = 4'b0000;
      for (int w = 0; w < 10 && arb_if.grant != 4'b0000; w++) tick();
   endtask

   task automatic test_random();
      logic [N-1:0] flip;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) flip[i] = ($urandom_range(0, 5) == 0);
         arb_if.req = arb_if.req ^ flip;
         reset = ($urandom_range(0, 99) == 0);
         tick();
         n_checks++;
         if (arb_if.grant !== exp_grant || arb_if.busy !== exp_busy || arb_if.owner !== exp_owner)
            $display("FAIL rand cyc %0d: grant=%b busy=%b owner=%0d expected %b/%b/%0d",
                     c, arb_if.grant, arb_if.busy, arb_if.owner, exp_grant, exp_busy, exp_owner);
         else n_pass++;
         n_checks++;
         if (!$onehot0(arb_if.grant) || arb_if.busy !== (|arb_if.grant))
            $display("FAIL rand_inv cyc %0d: grant=%b busy=%b", c, arb_if.grant, arb_if.busy);
         else n_pass++;
      end
      reset = 1'b0;
      arb_if.req = 4'b0000;
   endtask

   initial begin
      m_owner = -1;
      m_ptr   = 0;
      m_last  = 0;
      for (int j = 0; j < SYNC; j++) hist[j] = '0;
      reset = 1'b1;
      arb_if.req = 4'b0000;
      test_reset();
      test_single_latency();
      test_all_requesters();
      test_no_preempt();
      test_reset_mid_grant();
      test_pulse();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_checks);
      $fatal(1);
   end
endmodule
